mtr_duty_slew: RTL and testbench
================================

# mtr_duty_slew

Slew-rate limiter and period-synchronous duty updater sitting directly upstream of the 11-bit PWM generator in each motor drive channel. Accepts a signed speed command, offsets it to an unsigned 11-bit duty (0x400 = stopped), and moves the output duty toward that target by at most a fixed step per PWM period. Duty changes only at PWM period boundaries, so the PWM never sees a mid-period change. An emergency-stop input ramps the duty to 0x400 at a faster brake rate.

## Interface
- STEP, default 11'd32: maximum duty change per PWM period in normal operation; legal 1..1023.
- STEP_BRK, default 11'd128: maximum duty change per PWM period while estop is asserted; legal 1..1023.
- clk  input  1  system clock; the same clock as the PWM generator.
- rst_n  input  1  asynchronous, active-low reset; shared with the PWM generator so the period counters stay aligned.
- cmd_spd  input  11  signed speed command, range -1024..+1023.
- cmd_vld  input  1  single-cycle strobe; latches cmd_spd as the new target.
- estop  input  1  level; while high, the target is forced to 0x400 and the rate is STEP_BRK.
- duty  output  11  registered duty to the PWM generator.
- at_target  output  1  registered; high when duty equals the effective target.
- prd_end  output  1  registered; high for one cycle during the last clock of each 2048-clock PWM period.

## Operation
- Target register tgt (11 bits): on cmd_vld, tgt = cmd_spd + 0x400 (MSB inverted; no saturation needed). Reset value is 0x400.
- Effective target is 0x400 when estop is high, otherwise tgt. cmd_vld during estop still updates tgt. After estop deasserts, the ramp resumes toward the latest tgt.
- Effective step is STEP_BRK when estop is high, otherwise STEP.
- Period counter prd_cnt is an 11-bit free-running counter: resets to 0, wraps 2047 -> 0, and matches the PWM generator's counter cycle for cycle.
- Duty update occurs only on the clock edge where prd_cnt == 2047:
  - diff = eff_tgt - duty, computed as 12-bit signed.
  - If |diff| <= step, duty = eff_tgt.
  - Otherwise duty = duty ± step, in the sign of diff.
  - No overshoot and no wrap past 0 or 2047.
- State machine with states IDLE, RAMP, BRAKE, evaluated every cycle:
  - IDLE: duty equals the effective target.
  - RAMP: duty differs from the effective target and estop is low.
  - BRAKE: estop is high and duty != 0x400.
  - Transitions follow the conditions directly. estop high with duty == 0x400 is IDLE.
- at_target = (state == IDLE), registered from the next-state value so it matches the duty register.
- Reset values: duty = 0x400, tgt = 0x400, prd_cnt = 0, state = IDLE, at_target = 1, prd_end = 0.

## Timing
- cmd_vld to tgt update: 1 clock.
- tgt to first duty change: at the next prd_cnt == 2047 edge. Worst case is 2048 clocks.
- Full swing from 0x000 to 0x7FF with STEP = 32 takes 64 periods; the last step is clipped to 31.
- prd_end is high during the cycle where prd_cnt == 2047 and low otherwise. duty changes on the edge that ends that cycle, so the PWM sees new duty at cnt == 0.
- cmd_vld coinciding with the update edge: the update uses the old tgt; the new tgt applies from the next period.
- estop rising on the update edge: the brake step and 0x400 target apply on that same edge (combinational on estop).
- Asynchronous reset mid-ramp: all registers return to reset values immediately. No partial step is retained.

## Structure
- A shared motor package holds:
  - DUTY_W = 11
  - DUTY_ZERO = 11'h400
  - PRD_LAST = 11'h7FF
  - the state enum type (IDLE, RAMP, BRAKE)
- One natural sub-module is mtr_prd_cnt: the period counter emitting prd_end. It is reusable by the PWM generator and by other period-synchronous blocks.
- The step/clip arithmetic stays inline in mtr_duty_slew.

## Test plan
- Reset release, no commands -> duty = 0x400, at_target = 1, prd_end pulses every 2048 clocks starting at clock 2047.
- cmd_spd = +256 (tgt 0x500), STEP = 32 -> duty goes 0x420, 0x440 … 0x500 over 8 periods; at_target rises with the final step.
- cmd_spd = -1024 from 0x400 -> 32 steps to 0x000, with no underflow. Then cmd_spd = +1023 -> 64 steps, last step clipped, reaching 0x7FF.
- At duty 0x600, assert estop -> steps of 128 to 0x400 in 4 periods, state BRAKE then IDLE. Deassert estop -> ramp back to 0x600 at STEP.
- cmd_vld on the prd_cnt == 2047 cycle -> that edge uses the old target; the new target starts stepping one period later.
- Assert rst_n low mid-ramp at duty 0x480 -> duty = 0x400, at_target = 1, prd_cnt = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mtr_pkg.sv
// Shared motor-drive definitions: duty width, the stopped duty code, the
// last count of a PWM period and the slew limiter state type.
package mtr_pkg;

    localparam int DUTY_W = 11;

    localparam logic [DUTY_W-1:0] DUTY_ZERO = 11'h400;
    localparam logic [DUTY_W-1:0] PRD_LAST  = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        BRAKE
    } slew_state_e;

endpackage

// File: rtl/mtr_prd_cnt.sv
// Free-running 2048-clock PWM period counter with a registered end-of-period
// flag that is high exactly while the count sits at its last value.
module mtr_prd_cnt
    import mtr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [DUTY_W-1:0] prd_cnt,
    output logic              prd_end
);

    // prd_end is registered from the count one below the last so it lines up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prd_cnt <= '0;
            prd_end <= 1'b0;
        end else begin
            prd_cnt <= prd_cnt + DUTY_W'(1);
            prd_end <= (prd_cnt == (PRD_LAST - DUTY_W'(1)));
        end
    end

endmodule

// File: rtl/mtr_duty_slew.sv
// Slew-rate limited duty updater: steps the PWM duty toward the commanded
// target once per PWM period, with a faster brake ramp to stop on estop.
module mtr_duty_slew
    import mtr_pkg::*;
#(
    parameter logic [DUTY_W-1:0] STEP     = 11'd32,
    parameter logic [DUTY_W-1:0] STEP_BRK = 11'd128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] cmd_spd,
    input  logic              cmd_vld,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target,
    output logic              prd_end
);

    logic [DUTY_W-1:0]   prd_cnt;
    logic [DUTY_W-1:0]   tgt;
    logic [DUTY_W-1:0]   eff_tgt;
    logic [DUTY_W-1:0]   eff_step;
    logic signed [DUTY_W:0] diff;
    logic [DUTY_W:0]     abs_diff;
    logic [DUTY_W-1:0]   duty_nxt;
    logic                upd;
    slew_state_e         state;
    slew_state_e         state_nxt;

    mtr_prd_cnt u_prd_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .prd_cnt (prd_cnt),
        .prd_end (prd_end)
    );

    assign upd = (prd_cnt == PRD_LAST);

    // estop acts combinationally so a brake request lands on the same update edge
    always_comb begin
        eff_tgt  = estop ? DUTY_ZERO : tgt;
        eff_step = estop ? STEP_BRK : STEP;
        diff     = $signed({1'b0, eff_tgt}) - $signed({1'b0, duty});
        abs_diff = diff[DUTY_W] ? (DUTY_W+1)'(-diff) : (DUTY_W+1)'(diff);
        duty_nxt = duty;
        if (upd) begin
            if (abs_diff <= {1'b0, eff_step}) begin
                duty_nxt = eff_tgt;
            end else if (diff[DUTY_W]) begin
                duty_nxt = duty - eff_step;
            end else begin
                duty_nxt = duty + eff_step;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (duty_nxt != eff_tgt) begin
                    state_nxt = estop ? BRAKE : RAMP;
                end
            end
            RAMP: begin
                if (duty_nxt == eff_tgt) begin
                    state_nxt = IDLE;
                end else if (estop) begin
                    state_nxt = BRAKE;
                end
            end
            BRAKE: begin
                if (duty_nxt == eff_tgt) begin
                    state_nxt = IDLE;
                end else if (!estop) begin
                    state_nxt = RAMP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command offset to unsigned duty is just an MSB flip of the two's complement value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt       <= DUTY_ZERO;
            duty      <= DUTY_ZERO;
            state     <= IDLE;
            at_target <= 1'b1;
        end else begin
            if (cmd_vld) begin
                tgt <= {~cmd_spd[DUTY_W-1], cmd_spd[DUTY_W-2:0]};
            end
            duty      <= duty_nxt;
            state     <= state_nxt;
            at_target <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_mtr_duty_slew.sv
// Randomized self-checking bench for mtr_duty_slew against a per-period
// arithmetic model of the target, slew step and period boundary.
module tb_mtr_duty_slew;

    localparam int STEP_V  = 160;
    localparam int BRK_V   = 400;
    localparam int N_CYC   = 70000;

    logic        clk;
    logic        rst_n;
    logic [10:0] cmd_spd;
    logic        cmd_vld;
    logic        estop;
    logic [10:0] duty;
    logic        at_target;
    logic        prd_end;

    int total = 0;
    int bad   = 0;

    int m_cnt;
    int m_tgt;
    int m_duty;
    int exp_at;
    int exp_end;
    int cmd_val;
    bit bnd_done;

    mtr_duty_slew #(
        .STEP     (11'(STEP_V)),
        .STEP_BRK (11'(BRK_V))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_spd   (cmd_spd),
        .cmd_vld   (cmd_vld),
        .estop     (estop),
        .duty      (duty),
        .at_target (at_target),
        .prd_end   (prd_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic issueCmd(input int v);
        cmd_val = v;
        cmd_spd = 11'(v);
        cmd_vld = 1'b1;
    endtask

    task automatic modelReset();
        m_cnt   = 0;
        m_tgt   = 1024;
        m_duty  = 1024;
        exp_at  = 1;
        exp_end = 0;
    endtask

    // Inputs for the coming clock edge, chosen from the cycle number and model state
    task automatic applyStimulus(input int cyc);
        cmd_vld = 1'b0;
        if (cyc == 10)         issueCmd(-1024);
        else if (cyc == 16000) issueCmd(1023);
        else if (cyc == 44100) issueCmd(512);
        else if (cyc == 60000) issueCmd(-200);
        else if (cyc >= 56000 && !bnd_done && m_cnt == 2047) begin
            issueCmd(-300);
            bnd_done = 1'b1;
        end else if (cyc > 64000 && $urandom_range(2999, 0) == 0) begin
            issueCmd(int'($urandom_range(2047, 0)) - 1024);
        end
        if (cyc == 44000) estop = 1'b1;
        if (cyc == 52000) estop = 1'b0;
        if (cyc > 64000 && $urandom_range(5999, 0) == 0) estop = ~estop;
    endtask

    // Reference behaviour for one clock edge, using the inputs held across it
    task automatic modelEdge();
        int eff;
        int stp;
        int d;
        eff = estop ? 1024 : m_tgt;
        stp = estop ? BRK_V : STEP_V;
        if (m_cnt == 2047) begin
            d = eff - m_duty;
            if (d <= stp && d >= -stp) m_duty = eff;
            else if (d > 0)            m_duty = m_duty + stp;
            else                       m_duty = m_duty - stp;
        end
        exp_at = (m_duty == eff) ? 1 : 0;
        if (cmd_vld) m_tgt = cmd_val + 1024;
        m_cnt   = (m_cnt + 1) % 2048;
        exp_end = (m_cnt == 2047) ? 1 : 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd_vld  = 1'b0;
        cmd_spd  = '0;
        cmd_val  = 0;
        estop    = 1'b0;
        bnd_done = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_duty", int'(duty), 1024);
        checkOutput("reset_at_target", int'(at_target), 1);
        checkOutput("reset_prd_end", int'(prd_end), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc == 62000) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("async_rst_duty", int'(duty), 1024);
                checkOutput("async_rst_at_target", int'(at_target), 1);
                checkOutput("async_rst_prd_end", int'(prd_end), 0);
                modelReset();
                cmd_vld = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            applyStimulus(cyc);
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput("duty", int'(duty), m_duty);
            checkOutput("prd_end", int'(prd_end), exp_end);
            checkOutput("at_target", int'(at_target), exp_at);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
